f2s_count_receiver: RTL and testbench
=====================================

# f2s_count_receiver

Receive-side block for a counter crossing into this clock domain from a faster foreign domain. It samples a Gray-coded count launched by the remote counter and synchronizes it through a flop chain. It then converts the value to binary, measures how far the remote counter advanced since the previous sample, and accumulates those steps. It flags an overrun when the remote domain advances too far between samples for the step count to be trusted.

## Interface
- `WIDTH`, 4: width of the crossing Gray count and of `count_bin`/`delta`.
- `SYNC_STAGES`, 2: synchronizer depth, minimum 2.
- `ACC_WIDTH`, 16: width of the `total` accumulator.
- `MAX_STEP`, 4: largest per-sample advance treated as legal, 1..2^WIDTH-1.

Ports:
- `clk`  in  1  single receive-domain clock; every flop in the block is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `gray_in`  in  WIDTH  Gray count from the foreign domain, registered there and asynchronous here.
- `clr_total`  in  1  synchronous request to clear `total`.
- `count_bin`  out  WIDTH  latest synchronized remote count, in binary.
- `delta`  out  WIDTH  advance since the previous sample, modulo 2^WIDTH.
- `update`  out  1  one-cycle pulse; high when `count_bin` takes a new, different value.
- `total`  out  ACC_WIDTH  saturating sum of all `delta` values since reset or clear.
- `overrun`  out  1  sticky error flag.

## Operation
- Reset values (asserted while `reset` is 0): `count_bin`=0, `delta`=0, `update`=0, `total`=0, `overrun`=0, synchronizer flops=0, state=INIT.
- FSM INIT:
  - Entered on reset.
  - Waits SYNC_STAGES cycles after `reset` deasserts so the chain holds real samples.
  - All outputs hold their reset values.
- FSM PRIME:
  - Lasts exactly one cycle.
  - Loads `count_bin` and the previous-sample register with the converted synchronizer output.
  - `update` stays 0, `delta` stays 0 and `total` is not touched, so the remote value present at startup is never counted as motion.
- FSM RUN:
  - Every cycle computes `d` = current binary sample minus previous sample, WIDTH bits, wrapping.
  - If `d` is 0: outputs hold and `update` is 0.
  - If `d` is nonzero:
    - `count_bin` takes the new sample.
    - `delta` takes `d`.
    - `update` pulses for one cycle.
    - `total` becomes `total`+`d`, saturating at 2^ACC_WIDTH-1.
  - If `d` > MAX_STEP, `overrun` is set to 1 and stays set until reset. `d` is still accumulated.
- Gray to binary: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1] XOR g[i].
- `clr_total` in RUN with no update the same cycle: `total` is 0 on the next cycle.
- `clr_total` with an update the same cycle: `total` becomes `d`, saturated to ACC_WIDTH.
- `clr_total` in INIT or PRIME: ignored.
- Wrap-around: moving from 2^WIDTH-1 to 0 gives `d`=1, not an error.
- `delta` holds its last value between updates.
- Reset asserted mid-operation: everything returns to its reset value at once, asynchronously. The block then re-runs INIT and PRIME.

## Timing
- Latency from a `gray_in` change to `count_bin` and `update`:
  - The change is first captured at clk edge N.
  - `count_bin`, `delta` and `update` change after edge N+SYNC_STAGES. That is 3 edges at the defaults.
- `total` updates on the same edge as `count_bin`, so there is no extra latency.
- Minimum spacing between `update` pulses is one cycle; back-to-back pulses are legal.
- From `reset` deassertion: SYNC_STAGES cycles in INIT, then 1 cycle in PRIME, then RUN.
- The first RUN comparison is made against the value loaded in PRIME.
- Each `gray_in` bit may go metastable independently; correctness depends only on the source changing one bit per remote edge.

## Structure
- Package `cdc_pkg` holds:
  - the FSM state enum (INIT, PRIME, RUN);
  - a `gray2bin` function parameterized by width;
  - a `bin2gray` function, shared with the transmit side.
- Sub-module `sync_chain` is a WIDTH-wide, SYNC_STAGES-deep flop synchronizer with asynchronous active-low reset. It carries the multi-stage-synchronizer attribute for timing constraints.
- Top level holds:
  - the FSM;
  - the INIT cycle counter, $clog2(SYNC_STAGES+1) bits;
  - the previous-sample register;
  - the subtractor, saturating accumulator and sticky `overrun`.

## Test plan
All scenarios use default parameters.
- Priming: hold `gray_in`=0110 (binary 4) through reset and release. Expect `count_bin`=4 on the PRIME edge, `update` never high, `total`=0.
- Single steps: drive Gray 0000→0001→0011→0010, one change every 3 clks. Expect three `update` pulses, `delta`=1 each time, `count_bin` 1,2,3, `total`=3, each appearing 3 edges after its change.
- Wrap and multi-step:
  - Drive binary 14→15→0 using Gray 1001→1000→0000. Expect `delta`=1 twice.
  - Then drive 0→3 in one sample (0000→0010, a legal one-bit change). Expect `delta`=3 and `overrun`=0.
- Overrun: jump from binary 0 to 6 in one sample. Expect `delta`=6, `overrun`=1, `total` increased by 6, and `overrun` still 1 after 20 idle clks.
- Clear collision:
  - Raise `clr_total` on the same cycle as an update with `d`=2. Expect `total`=2.
  - Raise `clr_total` again with no update. Expect `total`=0 on the next cycle.
- Reset mid-run: with `total`=9 and `overrun`=1, pulse `reset` low asynchronously between clk edges. Expect all outputs 0 immediately, then INIT and PRIME re-run with no `update`.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and Gray/binary helpers for counters that cross clock domains.
// Used by both the transmit and receive sides.
package cdc_pkg;

    localparam int unsigned CdcMaxWidth = 32;

    typedef enum logic [1:0] {
        StInit,
        StPrime,
        StRun
    } state_e;

    // Callers zero-extend to CdcMaxWidth and truncate the result back to width.
    function automatic logic [CdcMaxWidth-1:0] gray2bin(
        input logic [CdcMaxWidth-1:0] gray,
        input int unsigned            width
    );
        logic [CdcMaxWidth-1:0] masked;
        logic [CdcMaxWidth-1:0] bin;
        masked = '0;
        for (int i = 0; i < int'(CdcMaxWidth); i++) begin
            if (i < int'(width)) begin
                masked[i] = gray[i];
            end
        end
        // Each binary bit is the parity of its Gray bit and all bits above it.
        for (int i = 0; i < int'(CdcMaxWidth); i++) begin
            bin[i] = ^(masked >> i);
        end
        return bin;
    endfunction

    function automatic logic [CdcMaxWidth-1:0] bin2gray(input logic [CdcMaxWidth-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-bit flop synchronizer: WIDTH bits, STAGES deep, async active-low reset.
// Safe only for sources that change one bit at a time (Gray counts).
module sync_chain #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/f2s_count_receiver.sv
// Receive side of a fast-to-slow Gray counter crossing: synchronizes the count,
// converts to binary, accumulates per-sample advances and flags oversized steps.
module f2s_count_receiver
    import cdc_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACC_WIDTH   = 16,
    parameter int unsigned MAX_STEP    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clr_total,
    output logic [WIDTH-1:0]     count_bin,
    output logic [WIDTH-1:0]     delta,
    output logic                 update,
    output logic [ACC_WIDTH-1:0] total,
    output logic                 overrun
);

    localparam int unsigned CntWidth = $clog2(SYNC_STAGES + 1);
    localparam int unsigned SumWidth = ((ACC_WIDTH > WIDTH) ? ACC_WIDTH : WIDTH) + 1;
    localparam logic [CntWidth-1:0]  InitLast = CntWidth'(SYNC_STAGES - 1);
    localparam logic [ACC_WIDTH-1:0] AccMax   = '1;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0]      sync_gray;
    logic [WIDTH-1:0]      sample_bin;
    logic [WIDTH-1:0]      step;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      delta_q, delta_d;
    logic                  update_q, update_d;
    logic                  overrun_q, overrun_d;
    logic [ACC_WIDTH-1:0]  total_q, total_d;
    logic [SumWidth-1:0]   sum;

    sync_chain #(
        .WIDTH (WIDTH),
        .STAGES(SYNC_STAGES)
    ) u_sync_chain (
        .clk  (clk),
        .reset(reset),
        .d    (gray_in),
        .q    (sync_gray)
    );

    assign sample_bin = WIDTH'(gray2bin(CdcMaxWidth'(sync_gray), WIDTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // INIT lasts SYNC_STAGES cycles so the chain is flushed of its reset zeros.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            StInit: begin
                if (init_cnt_q == InitLast) begin
                    state_d = StPrime;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StPrime: state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        prev_d    = prev_q;
        count_d   = count_q;
        delta_d   = delta_q;
        update_d  = 1'b0;
        total_d   = total_q;
        overrun_d = overrun_q;
        step      = sample_bin - prev_q;
        sum       = '0;
        unique case (state_q)
            // Startup value becomes the reference without being counted as motion.
            StPrime: begin
                prev_d  = sample_bin;
                count_d = sample_bin;
            end
            StRun: begin
                prev_d = sample_bin;
                if (step != '0) begin
                    count_d  = sample_bin;
                    delta_d  = step;
                    update_d = 1'b1;
                    sum      = (clr_total ? '0 : SumWidth'(total_q)) + SumWidth'(step);
                    total_d  = (sum > SumWidth'(AccMax)) ? AccMax : ACC_WIDTH'(sum);
                    if (32'(step) > MAX_STEP) begin
                        overrun_d = 1'b1;
                    end
                end else if (clr_total) begin
                    total_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q    <= '0;
            count_q   <= '0;
            delta_q   <= '0;
            update_q  <= 1'b0;
            total_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            count_q   <= count_d;
            delta_q   <= delta_d;
            update_q  <= update_d;
            total_q   <= total_d;
            overrun_q <= overrun_d;
        end
    end

    assign count_bin = count_q;
    assign delta     = delta_q;
    assign update    = update_q;
    assign total     = total_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_f2s_count_receiver.sv
// Bench for f2s_count_receiver: scenario tasks plus randomized traffic checked
// against a sample-delay / step-sum reference model.
module tb_f2s_count_receiver;

    localparam int unsigned Width      = 4;
    localparam int unsigned SyncStages = 2;
    localparam int unsigned AccWidth   = 16;
    localparam int unsigned MaxStep    = 4;

    logic                clk;
    logic                reset;
    logic [Width-1:0]    gray_in;
    logic                clr_total;
    logic [Width-1:0]    count_bin;
    logic [Width-1:0]    delta;
    logic                update;
    logic [AccWidth-1:0] total;
    logic                overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [3:0] m_pipe[$];
    int         m_edges;
    logic [3:0] m_count;
    logic [3:0] m_delta;
    logic       m_update;
    logic       m_overrun;
    int         m_total;
    logic [3:0] cur;

    f2s_count_receiver #(
        .WIDTH      (Width),
        .SYNC_STAGES(SyncStages),
        .ACC_WIDTH  (AccWidth),
        .MAX_STEP   (MaxStep)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .gray_in  (gray_in),
        .clr_total(clr_total),
        .count_bin(count_bin),
        .delta    (delta),
        .update   (update),
        .total    (total),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic void m_reset();
        m_pipe = {};
        for (int i = 0; i < int'(SyncStages); i++) m_pipe.push_back(4'd0);
        m_edges   = 0;
        m_count   = 4'd0;
        m_delta   = 4'd0;
        m_update  = 1'b0;
        m_overrun = 1'b0;
        m_total   = 0;
    endfunction

    // The receiver acts on the remote value sampled SyncStages edges earlier.
    function automatic void m_edge();
        logic [3:0] seen;
        logic [3:0] d;
        int         sum;
        seen = m_pipe.pop_front();
        m_pipe.push_back(g2b(gray_in));
        m_update = 1'b0;
        if (m_edges < int'(SyncStages)) begin
            m_edges++;
        end else if (m_edges == int'(SyncStages)) begin
            m_count = seen;
            m_edges++;
        end else begin
            d = seen - m_count;
            if (d != 4'd0) begin
                m_update = 1'b1;
                m_delta  = d;
                m_count  = seen;
                sum      = (clr_total ? 0 : m_total) + int'(d);
                m_total  = (sum > 65535) ? 65535 : sum;
                if (int'(d) > int'(MaxStep)) m_overrun = 1'b1;
            end else if (clr_total) begin
                m_total = 0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) m_reset();
        else m_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] g);
        reset     = 1'b0;
        gray_in   = g;
        clr_total = 1'b0;
        m_reset();
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        gray_in   = 4'd0;
        clr_total = 1'b0;
        m_reset();
        step();
        step();
        n_checks++;
        if ({count_bin, delta, update, overrun, total} !== 27'd0) begin
            n_errors++;
            $display("FAIL reset.outputs got cnt=%0d dl=%0d up=%b ov=%b tot=%0d want all 0",
                     count_bin, delta, update, overrun, total);
        end
    endtask

    task automatic test_priming();
        do_reset(4'b0110);
        for (int c = 1; c <= 6; c++) begin
            step();
            n_checks++;
            if ({count_bin, delta, update, overrun, total} !==
                {m_count, m_delta, m_update, m_overrun, 16'(m_total)}) begin
                n_errors++;
                $display("FAIL prime.cycle%0d got %h/%h/%b/%b/%h want %h/%h/%b/%b/%h", c,
                         count_bin, delta, update, overrun, total,
                         m_count, m_delta, m_update, m_overrun, 16'(m_total));
            end
            n_checks++;
            if (update !== 1'b0 || total !== 16'd0) begin
                n_errors++;
                $display("FAIL prime.quiet%0d got up=%b tot=%0d want up=0 tot=0",
                         c, update, total);
            end
            if (c == 2 || c == 3) begin
                n_checks++;
                if (count_bin !== ((c == 3) ? 4'd4 : 4'd0)) begin
                    n_errors++;
                    $display("FAIL prime.count%0d got %0d want %0d", c, count_bin,
                             (c == 3) ? 4 : 0);
                end
            end
        end
    endtask

    task automatic test_single_steps();
        int n_upd;
        do_reset(4'd0);
        repeat (3) step();
        n_upd = 0;
        for (int k = 1; k <= 3; k++) begin
            cur     = 4'(k);
            gray_in = b2g(cur);
            for (int c = 1; c <= 3; c++) begin
                step();
                if (update === 1'b1) n_upd++;
                n_checks++;
                if ({count_bin, delta, update, overrun, total} !==
                    {m_count, m_delta, m_update, m_overrun, 16'(m_total)}) begin
                    n_errors++;
                    $display("FAIL single.v%0d.c%0d got %h/%h/%b/%b/%h want %h/%h/%b/%b/%h",
                             k, c, count_bin, delta, update, overrun, total,
                             m_count, m_delta, m_update, m_overrun, 16'(m_total));
                end
            end
            n_checks++;
            if ({count_bin, delta, update} !== {cur, 4'd1, 1'b1}) begin
                n_errors++;
                $display("FAIL single.arrive%0d got cnt=%0d dl=%0d up=%b want cnt=%0d dl=1 up=1",
                         k, count_bin, delta, update, cur);
            end
        end
        n_checks++;
        if (n_upd != 3 || total !== 16'd3) begin
            n_errors++;
            $display("FAIL single.summary got pulses=%0d tot=%0d want pulses=3 tot=3",
                     n_upd, total);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] seq [14];
        for (int i = 0; i < 11; i++) seq[i] = 4'(i + 4);
        seq[11] = 4'd15;
        seq[12] = 4'd0;
        seq[13] = 4'd3;
        for (int k = 0; k < 14; k++) begin
            cur     = seq[k];
            gray_in = b2g(cur);
            for (int c = 1; c <= 3; c++) begin
                step();
                n_checks++;
                if ({count_bin, delta, update, overrun, total} !==
                    {m_count, m_delta, m_update, m_overrun, 16'(m_total)}) begin
                    n_errors++;
                    $display("FAIL wrap.v%0d.c%0d got %h/%h/%b/%b/%h want %h/%h/%b/%b/%h",
                             cur, c, count_bin, delta, update, overrun, total,
                             m_count, m_delta, m_update, m_overrun, 16'(m_total));
                end
            end
            if (k >= 11) begin
                n_checks++;
                if ({delta, overrun} !== {((k == 13) ? 4'd3 : 4'd1), 1'b0}) begin
                    n_errors++;
                    $display("FAIL wrap.step%0d got dl=%0d ov=%b want dl=%0d ov=0",
                             cur, delta, overrun, (k == 13) ? 3 : 1);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [3:0] seq [5];
        int         base;
        seq  = '{4'd7, 4'd11, 4'd15, 4'd0, 4'd6};
        base = 0;
        for (int k = 0; k < 5; k++) begin
            base    = m_total;
            cur     = seq[k];
            gray_in = b2g(cur);
            for (int c = 1; c <= 3; c++) begin
                step();
                n_checks++;
                if ({count_bin, delta, update, overrun, total} !==
                    {m_count, m_delta, m_update, m_overrun, 16'(m_total)}) begin
                    n_errors++;
                    $display("FAIL overrun.v%0d.c%0d got %h/%h/%b/%b/%h want %h/%h/%b/%b/%h",
                             cur, c, count_bin, delta, update, overrun, total,
                             m_count, m_delta, m_update, m_overrun, 16'(m_total));
                end
            end
            n_checks++;
            if (overrun !== (k == 4)) begin
                n_errors++;
                $display("FAIL overrun.flag%0d got %b want %b", k, overrun, k == 4);
            end
        end
        n_checks++;
        if ({delta, total} !== {4'd6, 16'(base + 6)}) begin
            n_errors++;
            $display("FAIL overrun.jump got dl=%0d tot=%0d want dl=6 tot=%0d",
                     delta, total, base + 6);
        end
        repeat (20) step();
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun.sticky got %b want 1", overrun);
        end
    endtask

    task automatic test_clear();
        cur     = 4'd8;
        gray_in = b2g(cur);
        step();
        step();
        clr_total = 1'b1;
        step();
        clr_total = 1'b0;
        n_checks++;
        if ({update, delta, total} !== {1'b1, 4'd2, 16'd2} || total !== 16'(m_total)) begin
            n_errors++;
            $display("FAIL clear.collide got up=%b dl=%0d tot=%0d want up=1 dl=2 tot=2",
                     update, delta, total);
        end
        clr_total = 1'b1;
        step();
        clr_total = 1'b0;
        n_checks++;
        if ({update, total} !== {1'b0, 16'd0} || total !== 16'(m_total)) begin
            n_errors++;
            $display("FAIL clear.idle got up=%b tot=%0d want up=0 tot=0", update, total);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq [3];
        seq = '{4'd12, 4'd0, 4'd1};
        for (int k = 0; k < 3; k++) begin
            cur     = seq[k];
            gray_in = b2g(cur);
            repeat (3) step();
        end
        n_checks++;
        if ({total, overrun} !== {16'd9, 1'b1}) begin
            n_errors++;
            $display("FAIL midreset.before got tot=%0d ov=%b want tot=9 ov=1", total, overrun);
        end
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        n_checks++;
        if ({count_bin, delta, update, overrun, total} !== 27'd0) begin
            n_errors++;
            $display("FAIL midreset.async got cnt=%0d dl=%0d up=%b ov=%b tot=%0d want all 0",
                     count_bin, delta, update, overrun, total);
        end
        step();
        reset = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            n_checks++;
            if ({count_bin, delta, update, overrun, total} !==
                {m_count, m_delta, m_update, m_overrun, 16'(m_total)} || update !== 1'b0) begin
                n_errors++;
                $display("FAIL midreset.c%0d got %h/%h/%b/%b/%h want %h/%h/0/%b/%h", c,
                         count_bin, delta, update, overrun, total,
                         m_count, m_delta, m_overrun, 16'(m_total));
            end
            if (c == 3) begin
                n_checks++;
                if (count_bin !== 4'd1) begin
                    n_errors++;
                    $display("FAIL midreset.prime got %0d want 1", count_bin);
                end
            end
        end
    endtask

    task automatic test_random();
        int inc;
        int hold;
        for (int n = 0; n < 300; n++) begin
            inc       = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 15))
                                                    : int'($urandom_range(0, 4));
            hold      = int'($urandom_range(1, 3));
            cur       = 4'(int'(cur) + inc);
            gray_in   = b2g(cur);
            clr_total = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < hold; c++) begin
                step();
                n_checks++;
                if ({count_bin, delta, update, overrun, total} !==
                    {m_count, m_delta, m_update, m_overrun, 16'(m_total)}) begin
                    n_errors++;
                    $display("FAIL random.n%0d got %h/%h/%b/%b/%h want %h/%h/%b/%b/%h", n,
                             count_bin, delta, update, overrun, total,
                             m_count, m_delta, m_update, m_overrun, 16'(m_total));
                end
            end
        end
        clr_total = 1'b0;
    endtask

    task automatic test_back_to_back_saturation();
        for (int n = 0; n < 4600; n++) begin
            cur     = cur + 4'd15;
            gray_in = b2g(cur);
            step();
            n_checks++;
            if ({count_bin, delta, update, overrun, total} !==
                {m_count, m_delta, m_update, m_overrun, 16'(m_total)}) begin
                n_errors++;
                $display("FAIL b2b.n%0d got %h/%h/%b/%b/%h want %h/%h/%b/%b/%h", n,
                         count_bin, delta, update, overrun, total,
                         m_count, m_delta, m_update, m_overrun, 16'(m_total));
            end
        end
        n_checks++;
        if ({update, delta, total} !== {1'b1, 4'd15, 16'hffff}) begin
            n_errors++;
            $display("FAIL b2b.saturate got up=%b dl=%0d tot=%0d want up=1 dl=15 tot=65535",
                     update, delta, total);
        end
    endtask

    initial begin
        cur = 4'd0;
        test_reset();
        test_priming();
        test_single_steps();
        test_wrap();
        test_overrun();
        test_clear();
        test_reset_mid();
        test_random();
        test_back_to_back_saturation();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
